// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin arbitration of host pixel writes and a rectangle-fill engine onto one video buffer write port
module fb_write_arbiter #(
  parameter int HD          = 1280,
  parameter int VD          = 1024,
  parameter int X_BITS      = 11,
  parameter int Y_BITS      = 11,
  parameter int GATE_VBLANK = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [X_BITS-1:0] host_x_i,
  input  logic [Y_BITS-1:0] host_y_i,
  input  logic [1:0]        host_color_i,
  input  logic              fill_start_i,
  input  logic [X_BITS-1:0] fill_x0_i,
  input  logic [X_BITS-1:0] fill_x1_i,
  input  logic [Y_BITS-1:0] fill_y0_i,
  input  logic [Y_BITS-1:0] fill_y1_i,
  input  logic [1:0]        fill_color_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic              fill_err_o,
  output logic              host_drop_o,
  output logic              we_o,
  output logic [X_BITS-1:0] addr_x_o,
  output logic [Y_BITS-1:0] addr_y_o,
  output logic [1:0]        color_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [X_BITS:0] HD_L = (X_BITS+1)'(HD);
  localparam logic [Y_BITS:0] VD_L = (Y_BITS+1)'(VD);
  state_t state, state_d;
  logic [X_BITS-1:0] x0, x1, cx;
  logic [Y_BITS-1:0] y0, y1, cy;
  logic [1:0] fcol;
  logic last_host, permit, fill_req, host_gnt, fill_gnt, host_ok, cmd_ok, start_ok, row_end, last_px;
  assign permit   = (GATE_VBLANK == 0) || vblank_i;
  assign fill_req = state == RUN;
  assign host_gnt = !rst && permit && host_valid_i && (!fill_req || !last_host);
  assign fill_gnt = !rst && permit && fill_req && !host_gnt;
  assign host_ready_o = host_gnt;
  assign host_ok  = ({1'b0, host_x_i} < HD_L) && ({1'b0, host_y_i} < VD_L);
  assign cmd_ok   = (fill_x0_i <= fill_x1_i) && (fill_y0_i <= fill_y1_i) &&
                    ({1'b0, fill_x1_i} < HD_L) && ({1'b0, fill_y1_i} < VD_L);
  assign start_ok = state == IDLE && fill_start_i && cmd_ok;
  assign row_end  = cx == x1;
  assign last_px  = row_end && cy == y1;
  assign fill_busy_o = state != IDLE;
  assign fill_done_o = state == DONE;
  // next fill state: RUN leaves only once the final pixel is granted, DONE is a single cycle
  always_comb begin
    state_d = state;
    state_d = (state == IDLE) ? (start_ok ? RUN : IDLE) :
              (state == RUN)  ? ((fill_gnt && last_px) ? DONE : RUN) : IDLE;
  end
  // fill state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end
  // latch the accepted command and walk the raster cursor on each fill grant
  always_ff @(posedge clk) begin
    if (rst) begin
      x0 <= '0; x1 <= '0; y0 <= '0; y1 <= '0; cx <= '0; cy <= '0; fcol <= '0;
    end else if (start_ok) begin
      x0 <= fill_x0_i; x1 <= fill_x1_i; y0 <= fill_y0_i; y1 <= fill_y1_i;
      cx <= fill_x0_i; cy <= fill_y0_i; fcol <= fill_color_i;
    end else if (fill_gnt) begin
      cx <= row_end ? x0 : cx + 1'b1;
      cy <= (row_end && !last_px) ? cy + 1'b1 : cy;
    end
  end
  // round-robin pointer and registered write port; out-of-range host writes are swallowed
  always_ff @(posedge clk) begin
    if (rst) begin
      last_host <= 1'b0; we_o <= 1'b0; host_drop_o <= 1'b0; fill_err_o <= 1'b0;
      addr_x_o <= '0; addr_y_o <= '0; color_o <= '0;
    end else begin
      if (host_gnt || fill_gnt) last_host <= host_gnt;
      we_o        <= (host_gnt && host_ok) || fill_gnt;
      host_drop_o <= host_gnt && !host_ok;
      fill_err_o  <= state == IDLE && fill_start_i && !cmd_ok;
      if (host_gnt && host_ok) begin
        addr_x_o <= host_x_i; addr_y_o <= host_y_i; color_o <= host_color_i;
      end else if (fill_gnt) begin
        addr_x_o <= cx; addr_y_o <= cy; color_o <= fcol;
      end
    end
  end
endmodule
